// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory stage: control-bundle layout, RV32I funct3 codes and FSM states.
// The optional misalignment trap (MEM_MISALIGN_TRAP_EN) uses is_misaligned() below.
package mem_stage_pkg;

    localparam int CONTROL_SIGNALS_WIDTH = 8;

    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_WRITE  = 3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   is_misaligned = offset[0];
            2'b10:   is_misaligned = |offset;
            default: is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero extension,
// and store strobe generation with lane-replicated write data.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_word,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_data,
    output logic [3:0]  o_store_strb
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_load_word[7:0];
        case (i_offset)
            2'd1:    w_byte = i_load_word[15:8];
            2'd2:    w_byte = i_load_word[23:16];
            2'd3:    w_byte = i_load_word[31:24];
            default: w_byte = i_load_word[7:0];
        endcase
        w_half = i_offset[1] ? i_load_word[31:16] : i_load_word[15:0];

        case (i_funct3)
            F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_load_data = {24'd0, w_byte};
            F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_load_data = {16'd0, w_half};
            default: o_load_data = i_load_word;
        endcase
    end

    // Halves ignore offset[0]; words ignore the whole offset.
    always_comb begin
        case (i_funct3[1:0])
            2'b00: begin
                o_store_strb = 4'b0001 << i_offset;
                o_store_data = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                o_store_strb = i_offset[1] ? 4'b1100 : 4'b0011;
                o_store_data = {2{i_store_data[15:0]}};
            end
            default: begin
                o_store_strb = 4'b1111;
                o_store_data = i_store_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls upstream while a request is outstanding,
// and owns the MEM/WB register. Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ex_mem_valid,
    input  logic [31:0]                      ex_mem_alu_result,
    input  logic [31:0]                      ex_mem_rs2_data,
    input  logic [2:0]                       ex_mem_funct3,
    input  logic [4:0]                       ex_mem_rd,
    input  logic [CONTROL_SIGNALS_WIDTH-1:0] ex_mem_control_signals,
    output logic                             dmem_req,
    output logic                             dmem_we,
    output logic [ADDR_WIDTH-1:0]            dmem_addr,
    output logic [31:0]                      dmem_wdata,
    output logic [3:0]                       dmem_wstrb,
    input  logic                             dmem_ready,
    input  logic [31:0]                      dmem_rdata,
    output logic                             mem_stall,
    output logic                             mem_wb_valid,
    output logic [31:0]                      mem_wb_alu_result,
    output logic [31:0]                      mem_wb_mem_data,
    output logic [4:0]                       mem_wb_rd,
    output logic [CONTROL_SIGNALS_WIDTH-1:0] mem_wb_control_signals,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic                             mem_misaligned,
`endif
    output mem_state_t                       o_dbg_state
);

    mem_state_t r_state, w_next_state;

    logic                             r_dmem_req, r_dmem_we;
    logic [ADDR_WIDTH-1:0]            r_dmem_addr;
    logic [31:0]                      r_dmem_wdata, r_load_buf;
    logic [3:0]                       r_dmem_wstrb;
    logic                             r_wb_valid;
    logic [31:0]                      r_wb_alu_result, r_wb_mem_data;
    logic [4:0]                       r_wb_rd;
    logic [CONTROL_SIGNALS_WIDTH-1:0] r_wb_ctrl;

    logic                             w_access, w_misaligned, w_issue, w_stall, w_wb_capture;
    logic [31:0]                      w_load_data, w_store_data;
    logic [3:0]                       w_store_strb;
    logic [CONTROL_SIGNALS_WIDTH-1:0] w_wb_ctrl;

    assign w_access = ex_mem_valid &
                      (ex_mem_control_signals[CTRL_MEM_READ] | ex_mem_control_signals[CTRL_MEM_WRITE]);

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_misaligned;
    assign w_misaligned   = w_access & is_misaligned(ex_mem_funct3, ex_mem_alu_result[1:0]);
    assign mem_misaligned = r_misaligned;
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_issue = w_access & ~w_misaligned;

    // EX/MEM is frozen by the stall, so the same lane unit serves issue (IDLE) and load return (WAIT).
    mem_align u_align (
        .i_funct3     (ex_mem_funct3),
        .i_offset     (ex_mem_alu_result[1:0]),
        .i_store_data (ex_mem_rs2_data),
        .i_load_word  (dmem_rdata),
        .o_load_data  (w_load_data),
        .o_store_data (w_store_data),
        .o_store_strb (w_store_strb)
    );

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_stall      = 1'b1;
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_stall = 1'b1;
                if (dmem_ready) w_next_state = ST_DONE;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_wb_capture = ((r_state == ST_IDLE) & ex_mem_valid & ~w_issue) | (r_state == ST_DONE);

    always_comb begin
        w_wb_ctrl = ex_mem_control_signals;
        if (w_misaligned) w_wb_ctrl[CTRL_REG_WRITE] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_dmem_req      <= 1'b0;
            r_dmem_we       <= 1'b0;
            r_dmem_addr     <= '0;
            r_dmem_wdata    <= '0;
            r_dmem_wstrb    <= '0;
            r_load_buf      <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_alu_result <= '0;
            r_wb_mem_data   <= '0;
            r_wb_rd         <= '0;
            r_wb_ctrl       <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misaligned    <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;

            if ((r_state == ST_IDLE) && w_issue) begin
                r_dmem_req   <= 1'b1;
                r_dmem_we    <= ex_mem_control_signals[CTRL_MEM_WRITE];
                r_dmem_addr  <= {ex_mem_alu_result[ADDR_WIDTH-1:2], 2'b00};
                r_dmem_wdata <= w_store_data;
                r_dmem_wstrb <= ex_mem_control_signals[CTRL_MEM_WRITE] ? w_store_strb : 4'b0000;
            end

            if ((r_state == ST_WAIT) && dmem_ready) begin
                r_dmem_req <= 1'b0;
                r_load_buf <= r_dmem_we ? 32'd0 : w_load_data;
            end

            if (w_wb_capture) begin
                r_wb_valid      <= 1'b1;
                r_wb_alu_result <= ex_mem_alu_result;
                r_wb_mem_data   <= (r_state == ST_DONE) ? r_load_buf : 32'd0;
                r_wb_rd         <= ex_mem_rd;
                r_wb_ctrl       <= w_wb_ctrl;
            end else begin
                r_wb_valid      <= 1'b0;
                r_wb_alu_result <= '0;
                r_wb_mem_data   <= '0;
                r_wb_rd         <= '0;
                r_wb_ctrl       <= '0;
            end

`ifdef MEM_MISALIGN_TRAP_EN
            r_misaligned <= (r_state == ST_IDLE) & w_misaligned;
`endif
        end
    end

    assign dmem_req               = r_dmem_req;
    assign dmem_we                = r_dmem_we;
    assign dmem_addr              = r_dmem_addr;
    assign dmem_wdata             = r_dmem_wdata;
    assign dmem_wstrb             = r_dmem_wstrb;
    assign mem_stall              = w_stall;
    assign mem_wb_valid           = r_wb_valid;
    assign mem_wb_alu_result      = r_wb_alu_result;
    assign mem_wb_mem_data        = r_wb_mem_data;
    assign mem_wb_rd              = r_wb_rd;
    assign mem_wb_control_signals = r_wb_ctrl;
    assign o_dbg_state            = r_state;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized instruction stream
// compared against an arithmetic reference model and an expected MEM/WB queue.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int CW = CONTROL_SIGNALS_WIDTH;
    localparam int EW = 32 + 32 + 5 + CW;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_mem_valid;
    logic [31:0]   ex_mem_alu_result, ex_mem_rs2_data;
    logic [2:0]    ex_mem_funct3;
    logic [4:0]    ex_mem_rd;
    logic [CW-1:0] ex_mem_control_signals;
    logic          dmem_req, dmem_we;
    logic [31:0]   dmem_addr, dmem_wdata;
    logic [3:0]    dmem_wstrb;
    logic          dmem_ready;
    logic [31:0]   dmem_rdata;
    logic          mem_stall;
    logic          mem_wb_valid;
    logic [31:0]   mem_wb_alu_result, mem_wb_mem_data;
    logic [4:0]    mem_wb_rd;
    logic [CW-1:0] mem_wb_control_signals;
`ifdef MEM_MISALIGN_TRAP_EN
    logic          mem_misaligned;
`endif
    mem_state_t    dbg_state;

    mem_stage #(.ADDR_WIDTH(32)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ex_mem_valid           (ex_mem_valid),
        .ex_mem_alu_result      (ex_mem_alu_result),
        .ex_mem_rs2_data        (ex_mem_rs2_data),
        .ex_mem_funct3          (ex_mem_funct3),
        .ex_mem_rd              (ex_mem_rd),
        .ex_mem_control_signals (ex_mem_control_signals),
        .dmem_req               (dmem_req),
        .dmem_we                (dmem_we),
        .dmem_addr              (dmem_addr),
        .dmem_wdata             (dmem_wdata),
        .dmem_wstrb             (dmem_wstrb),
        .dmem_ready             (dmem_ready),
        .dmem_rdata             (dmem_rdata),
        .mem_stall              (mem_stall),
        .mem_wb_valid           (mem_wb_valid),
        .mem_wb_alu_result      (mem_wb_alu_result),
        .mem_wb_mem_data        (mem_wb_mem_data),
        .mem_wb_rd              (mem_wb_rd),
        .mem_wb_control_signals (mem_wb_control_signals),
`ifdef MEM_MISALIGN_TRAP_EN
        .mem_misaligned         (mem_misaligned),
`endif
        .o_dbg_state            (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [EW-1:0] exp_q[$];

    localparam logic [CW-1:0] CTRL_ALU = CW'(1 << CTRL_REG_WRITE);
    localparam logic [CW-1:0] CTRL_LD  = CW'((1 << CTRL_REG_WRITE) | (1 << CTRL_MEM_TO_REG) | (1 << CTRL_MEM_READ));
    localparam logic [CW-1:0] CTRL_ST  = CW'(1 << CTRL_MEM_WRITE);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        logic [31:0] b, h;
        b = (rdata >> (8 * (addr % 4))) % 256;
        h = (rdata >> (16 * ((addr % 4) / 2))) % 65536;
        case (f3)
            F3_LB:   return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            F3_LBU:  return b;
            F3_LH:   return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            F3_LHU:  return h;
            default: return rdata;
        endcase
    endfunction

    function automatic logic [31:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            F3_SB:   return 32'd1 << (addr % 4);
            F3_SH:   return 32'd3 << (2 * ((addr % 4) / 2));
            default: return 32'd15;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_SB:   return (d % 256) * 32'h0101_0101;
            F3_SH:   return (d % 65536) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    task automatic check_bubble(input string tag);
        check_eq({tag, "_wb_valid"}, 32'(mem_wb_valid), 32'd0);
        check_eq({tag, "_wb_fields"},
                 32'((|mem_wb_alu_result) | (|mem_wb_mem_data) | (|mem_wb_rd) | (|mem_wb_control_signals)), 32'd0);
    endtask

    task automatic check_wb_entry(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_underflow"}, 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check_eq({tag, "_wb_valid"}, 32'(mem_wb_valid), 32'd1);
        check_eq({tag, "_wb_alu"},   mem_wb_alu_result, e[EW-1 -: 32]);
        check_eq({tag, "_wb_data"},  mem_wb_mem_data,   e[EW-33 -: 32]);
        check_eq({tag, "_wb_rd"},    32'(mem_wb_rd),    32'(e[CW+4 -: 5]));
        check_eq({tag, "_wb_ctrl"},  32'(mem_wb_control_signals), 32'(e[CW-1:0]));
    endtask

    // ---------------- drivers ----------------
    task automatic run_instr(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                             input logic [4:0] rd, input logic [CW-1:0] ctrl, input int waits,
                             input logic [31:0] rdata);
        logic        is_mem;
        logic [31:0] exp_data;
        is_mem   = ctrl[CTRL_MEM_READ] | ctrl[CTRL_MEM_WRITE];
        exp_data = ctrl[CTRL_MEM_READ] ? model_load(f3, alu, rdata) : 32'd0;
        exp_q.push_back({alu, exp_data, rd, ctrl});

        ex_mem_valid           = 1'b1;
        ex_mem_alu_result      = alu;
        ex_mem_rs2_data        = rs2;
        ex_mem_funct3          = f3;
        ex_mem_rd              = rd;
        ex_mem_control_signals = ctrl;
        dmem_ready             = 1'($urandom_range(0, 1));
        dmem_rdata             = $urandom;
        #1 check_eq("stall_idle", 32'(mem_stall), 32'(is_mem));
        @(posedge clk); #1;

        if (!is_mem) begin
            check_wb_entry("pass");
            check_eq("pass_no_req", 32'(dmem_req), 32'd0);
            return;
        end

        check_eq("issue_req",  32'(dmem_req), 32'd1);
        check_eq("issue_we",   32'(dmem_we), 32'(ctrl[CTRL_MEM_WRITE]));
        check_eq("issue_addr", dmem_addr, alu - (alu % 4));
        check_eq("issue_strb", 32'(dmem_wstrb), ctrl[CTRL_MEM_WRITE] ? model_strb(f3, alu) : 32'd0);
        if (ctrl[CTRL_MEM_WRITE]) check_eq("issue_wdata", dmem_wdata, model_wdata(f3, rs2));
        check_bubble("issue");

        for (int w = 0; w < waits; w++) begin
            dmem_ready = 1'b0;
            dmem_rdata = $urandom;
            #1 check_eq("stall_wait", 32'(mem_stall), 32'd1);
            @(posedge clk); #1;
            check_eq("req_hold", 32'(dmem_req), 32'd1);
            check_bubble("wait");
        end

        dmem_ready = 1'b1;
        dmem_rdata = rdata;
        #1 check_eq("stall_ready", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        check_eq("req_drop", 32'(dmem_req), 32'd0);
        check_eq("state_done", 32'(dbg_state), 32'(ST_DONE));
        check_bubble("ready");

        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #1 check_eq("stall_done", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check_wb_entry("done");
        check_eq("done_no_req", 32'(dmem_req), 32'd0);
    endtask

    task automatic run_bubble();
        ex_mem_valid           = 1'b0;
        ex_mem_alu_result      = $urandom;
        ex_mem_control_signals = CTRL_LD;
        dmem_ready             = 1'($urandom_range(0, 1));
        #1 check_eq("bubble_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check_bubble("bubble");
        check_eq("bubble_no_req", 32'(dmem_req), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [2:0] ld_f3[5] = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    logic [2:0] st_f3[3] = '{F3_SB, F3_SH, F3_SW};

    initial begin
        rst                    = 1'b1;
        ex_mem_valid           = 1'b0;
        ex_mem_alu_result      = '0;
        ex_mem_rs2_data        = '0;
        ex_mem_funct3          = '0;
        ex_mem_rd              = '0;
        ex_mem_control_signals = '0;
        dmem_ready             = 1'b0;
        dmem_rdata             = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_req",   32'(dmem_req), 32'd0);
        check_eq("rst_we",    32'(dmem_we), 32'd0);
        check_eq("rst_addr",  dmem_addr, 32'd0);
        check_eq("rst_wdata", dmem_wdata, 32'd0);
        check_eq("rst_strb",  32'(dmem_wstrb), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_bubble("rst");
        rst = 1'b0;

        // Directed cases
        run_instr(32'hDEAD_BEEF, 32'h0, 3'b000, 5'd5, CTRL_ALU, 0, 32'h0);
        run_instr(32'h0000_0100, 32'h0, F3_LW,  5'd6, CTRL_LD,  1, 32'hCAFE_BABE);
        run_instr(32'h0000_0103, 32'h0, F3_LB,  5'd7, CTRL_LD,  0, 32'h80FF_1234);
        run_instr(32'h0000_0103, 32'h0, F3_LBU, 5'd8, CTRL_LD,  0, 32'h80FF_1234);
        run_instr(32'h0000_0102, 32'h0, F3_LH,  5'd9, CTRL_LD,  2, 32'h80FF_1234);
        run_instr(32'h0000_0201, 32'h0000_00AB, F3_SB, 5'd0, CTRL_ST, 0, 32'h0);
        run_instr(32'h0000_0202, 32'h1234_5678, F3_SH, 5'd0, CTRL_ST, 1, 32'h0);
        run_bubble();

        // Reset while waiting on the bus, then a stale ready
        ex_mem_valid           = 1'b1;
        ex_mem_alu_result      = 32'h0000_0300;
        ex_mem_funct3          = F3_LW;
        ex_mem_rd              = 5'd3;
        ex_mem_control_signals = CTRL_LD;
        dmem_ready             = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_req", 32'(dmem_req), 32'd1);
        rst          = 1'b1;
        ex_mem_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_req",   32'(dmem_req), 32'd0);
        check_eq("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check_bubble("midrst");
        rst        = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1111_2222;
        #1 check_eq("stale_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check_eq("stale_req",   32'(dmem_req), 32'd0);
        check_eq("stale_state", 32'(dbg_state), 32'(ST_IDLE));
        check_bubble("stale");
        dmem_ready = 1'b0;

`ifdef MEM_MISALIGN_TRAP_EN
        ex_mem_valid           = 1'b1;
        ex_mem_alu_result      = 32'h0000_0102;
        ex_mem_funct3          = F3_LW;
        ex_mem_rd              = 5'd4;
        ex_mem_control_signals = CTRL_LD;
        #1 check_eq("mis_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        check_eq("mis_req",    32'(dmem_req), 32'd0);
        check_eq("mis_flag",   32'(mem_misaligned), 32'd1);
        check_eq("mis_valid",  32'(mem_wb_valid), 32'd1);
        check_eq("mis_regwr",  32'(mem_wb_control_signals[CTRL_REG_WRITE]), 32'd0);
        run_bubble();
        check_eq("mis_pulse",  32'(mem_misaligned), 32'd0);
`endif

        // Randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic [31:0] alu;
            logic [2:0]  f3;
            kind = $urandom_range(0, 9);
            alu  = $urandom;
            if (kind < 2) begin
                run_instr(alu, $urandom, 3'($urandom), 5'($urandom),
                          CTRL_ALU | CW'($urandom_range(0, 15) << 4), 0, 32'h0);
            end else if (kind < 7) begin
                f3 = ld_f3[kind - 2];
`ifdef MEM_MISALIGN_TRAP_EN
                if (f3[1:0] == 2'b01) alu[0] = 1'b0;
                if (f3[1:0] == 2'b10) alu[1:0] = 2'b00;
`endif
                run_instr(alu, $urandom, f3, 5'($urandom), CTRL_LD, $urandom_range(0, 3), $urandom);
            end else begin
                f3 = st_f3[kind - 7];
`ifdef MEM_MISALIGN_TRAP_EN
                if (f3[1:0] == 2'b01) alu[0] = 1'b0;
                if (f3[1:0] == 2'b10) alu[1:0] = 2'b00;
`endif
                run_instr(alu, $urandom, f3, 5'd0, CTRL_ST, $urandom_range(0, 3), $urandom);
            end
            if ($urandom_range(0, 4) == 0) run_bubble();
        end

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between EX/MEM and MEM/WB; owns the MEM/WB pipeline register whose `mem_wb_*` fields feed writeback.
- Issues load/store requests to the data memory over a req/ready handshake.
- Formats load data (byte/half/word, sign/zero extension) and generates store byte strobes.
- Stalls upstream stages while a bus access is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of `dmem_addr`; the low ADDR_WIDTH bits of the ALU result are used.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ex_mem_valid  in  1  instruction present in MEM
- ex_mem_alu_result  in  32  effective address or ALU result
- ex_mem_rs2_data  in  32  store data
- ex_mem_funct3  in  3  access size/sign (RV32I load/store encoding)
- ex_mem_rd  in  5  destination register
- ex_mem_control_signals  in  `CONTROL_SIGNALS_WIDTH  control bundle
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
- dmem_wdata  out  32  store data, lane-replicated
- dmem_wstrb  out  4  byte enables (0 for loads)
- dmem_ready  in  1  bus completes the request this cycle
- dmem_rdata  in  32  read word, valid when dmem_ready
- mem_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- mem_wb_valid  out  1  MEM/WB register fields
- mem_wb_alu_result  out  32  MEM/WB register field
- mem_wb_mem_data  out  32  MEM/WB register field
- mem_wb_rd  out  5  MEM/WB register field
- mem_wb_control_signals  out  `CONTROL_SIGNALS_WIDTH  MEM/WB register field

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All registered outputs are 0: dmem_req/we/addr/wdata/wstrb and all mem_wb_* fields.
  - The internal load buffer is cleared.
- Access = ex_mem_valid & (ctrl[`CTRL_MEM_READ] | ctrl[`CTRL_MEM_WRITE]).
- FSM states:
  - IDLE:
    - No access: mem_stall=0. MEM/WB captures the EX/MEM fields at the clock edge, with mem_data=0. This is a 1-cycle pass-through.
    - Access: mem_stall=1. At the edge, dmem_req<=1 and dmem_we/addr/wdata/wstrb are latched, state goes to WAIT, and MEM/WB captures a bubble (valid=0, control=0, other fields 0).
  - WAIT:
    - Request outputs are held stable. mem_stall=1. MEM/WB captures a bubble every cycle.
    - On dmem_ready: dmem_req<=0, the formatted load data is latched into the buffer, and state goes to DONE.
  - DONE:
    - mem_stall=0.
    - At the edge, MEM/WB captures the EX/MEM fields with mem_data = buffer (0 for stores). State goes to IDLE.
- Minimum memory-instruction occupancy is 3 cycles (IDLE, WAIT with ready, DONE). Each extra wait cycle adds 1.
- dmem_ready in IDLE or DONE is ignored.
- Back-to-back memory instructions: the instruction that enters after DONE starts in IDLE. The bus is never requested in two consecutive cycles across instructions.
- Loads, using off = addr[1:0]:
  - LB: sign-extends byte `off`.
  - LBU: zero-extends byte `off`.
  - LH: sign-extends half `addr[1]`.
  - LHU: zero-extends half `addr[1]`.
  - LW: full word.
- Stores:
  - SB: wstrb = 1<<off, wdata = {4{byte}}.
  - SH: wstrb = 4'b0011<<(addr[1]*2), wdata = {2{half}}.
  - SW: wstrb = 4'b1111.
- Reset mid-access (during WAIT) drops the request. A later dmem_ready is ignored.
- ex_mem_valid=0 in IDLE: MEM/WB captures a bubble and mem_stall=0.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- With the macro defined:
  - Misalignment is LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - A misaligned access in IDLE is never issued to the bus, and mem_stall stays 0.
  - MEM/WB captures the instruction with `CTRL_REG_WRITE` forced to 0.
  - Extra output mem_misaligned (1 bit) is registered and pulses for 1 cycle, aligned with that MEM/WB entry.
- Without the macro: offset bits beyond the access size are ignored (LW/SW use addr[1:0]=0, halves use addr[1] only), and mem_misaligned does not exist.

Decomposition:
- constants.v owns `CONTROL_SIGNALS_WIDTH`, `CTRL_MEM_TO_REG`, `CTRL_REG_WRITE`, `CTRL_MEM_READ`, `CTRL_MEM_WRITE`, the funct3 codes (`F3_LB`..`F3_SW`) and the FSM state encodings.
- One sub-module, mem_align: a combinational unit for load extraction/extension and store strobe/data replication. It is shared by the registered paths in mem_stage.

Test Plan:
- Non-memory op (alu_result=0xDEADBEEF, rd=5, reg_write=1) -> next edge: mem_wb_valid=1, alu_result=0xDEADBEEF, mem_data=0, mem_stall never 1.
- LW at 0x100, dmem_ready after 2 WAIT cycles with rdata=0xCAFEBABE -> dmem_addr=0x100, wstrb=0, bubbles in MEM/WB during the stall, then mem_data=0xCAFEBABE. Total 4 cycles in MEM.
- LB at 0x103 with rdata=0x80FF1234 -> mem_data=0xFFFFFF80. LBU at the same address -> 0x00000080. LH at 0x102 -> 0xFFFF80FF.
- SB of 0x000000AB at 0x201 -> dmem_we=1, addr=0x200, wstrb=4'b0010, wdata=0xABABABAB. SH at 0x202 -> wstrb=4'b1100.
- rst asserted during WAIT, then dmem_ready=1 the next cycle -> dmem_req=0, all mem_wb_* fields 0, state IDLE, no MEM/WB capture.
- With MEM_MISALIGN_TRAP_EN: LW at 0x102 -> dmem_req stays 0, mem_misaligned pulses 1 cycle, MEM/WB `CTRL_REG_WRITE`=0.
